ysyx_22050518_ifu_resp: RTL and testbench

Instruction-fetch responder: the memory-side end of the first stage's fetch interface. Takes the fetch address driven by the first stage, issues one 64-bit read per instruction to the instruction memory port, selects the 32-bit instruction word, and returns it with a valid flag. Honours pipeline back-pressure and discards in-flight fetches on a jump redirect.

---
 rtl/ysyx_22050518_ifu_resp.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_22050518_ifu_resp.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050518_ifu_resp.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050518_ifu_resp
//  Purpose  : Instruction-fetch responder. Samples the fetch address from the
//             first stage and issues one 64-bit read per instruction. It then
//             selects the 32-bit word and returns it with valid/error flags.
//             Honours back-pressure and drops in-flight fetches on flush.
//  Options  : YSYX_22050518_IFU_LINEBUF_EN - single 64-bit line buffer that
//             serves repeat hits without a memory request.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050518_ifu_resp #(
    parameter logic [31:0] RESET_IR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [63:0] ira,
    input  logic        fetch_ready,
    input  logic        flush,
    output logic [31:0] ir,
    output logic        ivalid,
    output logic        ierr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    input  logic        mem_resp_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    // Bits [1:0] of the fetch address only matter at sampling time, so they
    // are not stored.
    logic [63:2] fetch_addr_q, fetch_addr_d;
    logic [31:0] ir_q, ir_d;
    logic        ierr_q, ierr_d;
    logic        ivalid_q, ivalid_d;
    logic        req_valid_q, req_valid_d;

    logic        take_ira;
    logic [31:0] resp_word;
    logic        lb_hit;
    logic [31:0] lb_word;

    // Word select of the returning 64-bit beat by the stored address bit 2.
    assign resp_word = fetch_addr_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

`ifdef YSYX_22050518_IFU_LINEBUF_EN
    logic        lb_valid_q, lb_valid_d;
    logic [63:3] lb_tag_q, lb_tag_d;
    logic [63:0] lb_data_q, lb_data_d;
    logic        lb_resp;

    // A response is only consumed in WAIT/DRAIN; late beats elsewhere are
    // stale and must not pollute the buffer.
    assign lb_resp = mem_resp_valid && ((state_q == S_WAIT) || (state_q == S_DRAIN));
    assign lb_hit  = lb_valid_q && (lb_tag_q == ira[63:3]);
    assign lb_word = ira[2] ? lb_data_q[63:32] : lb_data_q[31:0];

    // Line buffer update: fill on clean responses, invalidate on bus errors.
    // A flushed response is still correct data for its address, so it fills.
    always_comb begin
        lb_valid_d = lb_valid_q;
        lb_tag_d   = lb_tag_q;
        lb_data_d  = lb_data_q;
        if (lb_resp) begin
            if (mem_resp_err) begin
                lb_valid_d = 1'b0;
            end else begin
                lb_valid_d = 1'b1;
                lb_tag_d   = fetch_addr_q[63:3];
                lb_data_d  = mem_resp_data;
            end
        end
    end

    // Line buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
        end else begin
            lb_valid_q <= lb_valid_d;
            lb_tag_q   <= lb_tag_d;
            lb_data_q  <= lb_data_d;
        end
    end
`else
    assign lb_hit  = 1'b0;
    assign lb_word = RESET_IR;
`endif

    // Next-state and registered-output computation for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        ir_d         = ir_q;
        ierr_d       = ierr_q;
        ivalid_d     = ivalid_q;
        req_valid_d  = req_valid_q;
        take_ira     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch_en && !flush) begin
                    take_ira = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    // Handshake completes even under flush; the response
                    // then has to be drained.
                    req_valid_d = 1'b0;
                    state_d     = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    req_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (flush) begin
                        // Response already here: nothing left to drain.
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_OUT;
                        ivalid_d = 1'b1;
                        ir_d     = resp_word;
                        ierr_d   = mem_resp_err;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_OUT: begin
                if (flush) begin
                    state_d  = S_IDLE;
                    ivalid_d = 1'b0;
                    ir_d     = RESET_IR;
                    ierr_d   = 1'b0;
                end else if (fetch_ready) begin
                    if (fetch_en) begin
                        take_ira = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        ivalid_d = 1'b0;
                        ir_d     = RESET_IR;
                        ierr_d   = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                ivalid_d    = 1'b0;
                req_valid_d = 1'b0;
                ir_d        = RESET_IR;
                ierr_d      = 1'b0;
            end
        endcase

        // Sampling a new address: misaligned -> immediate error, buffer hit
        // -> immediate data, otherwise start a memory read.
        if (take_ira) begin
            fetch_addr_d = ira[63:2];
            if (ira[1:0] != 2'b00) begin
                state_d     = S_OUT;
                ivalid_d    = 1'b1;
                ierr_d      = 1'b1;
                ir_d        = RESET_IR;
                req_valid_d = 1'b0;
            end else if (lb_hit) begin
                state_d     = S_OUT;
                ivalid_d    = 1'b1;
                ierr_d      = 1'b0;
                ir_d        = lb_word;
                req_valid_d = 1'b0;
            end else begin
                state_d     = S_REQ;
                ivalid_d    = 1'b0;
                ierr_d      = 1'b0;
                ir_d        = RESET_IR;
                req_valid_d = 1'b1;
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= '0;
            ir_q         <= RESET_IR;
            ierr_q       <= 1'b0;
            ivalid_q     <= 1'b0;
            req_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            ir_q         <= ir_d;
            ierr_q       <= ierr_d;
            ivalid_q     <= ivalid_d;
            req_valid_q  <= req_valid_d;
        end
    end

    assign ir            = ir_q;
    assign ierr          = ierr_q;
    assign ivalid        = ivalid_q;
    assign mem_req_valid = req_valid_q;
    // Request address is a pure function of the stored fetch address, so it
    // is stable for the whole REQ phase.
    assign mem_req_addr  = {fetch_addr_q[63:3], 3'b000};

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050518_ifu_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050518_ifu_resp
//  Purpose  : Self-checking bench for ysyx_22050518_ifu_resp with a simple
//             memory responder and an expected-instruction scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050518_ifu_resp;

`ifdef YSYX_22050518_IFU_LINEBUF_EN
    localparam logic LB = 1'b1;
`else
    localparam logic LB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [63:0] ira;
    logic        fetch_ready;
    logic        flush;
    logic [31:0] ir;
    logic        ivalid;
    logic        ierr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        mem_resp_err;

    ysyx_22050518_ifu_resp #(.RESET_IR(32'h00000013)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .ira            (ira),
        .fetch_ready    (fetch_ready),
        .flush          (flush),
        .ir             (ir),
        .ivalid         (ivalid),
        .ierr           (ierr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] sb_q[$];

    // Responder configuration / statistics
    int          ready_delay = 0;
    int          resp_delay  = 0;
    logic        err_resp    = 1'b0;
    logic        ovr_en      = 1'b0;
    logic [63:0] ovr_data    = 64'd0;
    int          req_count   = 0;
    int          resp_count  = 0;

    // Responder private state
    int          rdy_wait = 0;
    bit          pend     = 1'b0;
    int          pcnt     = 0;
    logic [63:0] paddr    = 64'd0;
    bit          pv       = 1'b0;
    bit          pr       = 1'b0;
    logic [63:0] pa       = 64'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [63:0] line);
        if (line == 64'h80000000) return 64'h00100093_00000513;
        return {line[31:0] ^ 32'hA5A5_5A5A, line[31:0] + 32'h0000_1111};
    endfunction

    function automatic logic [32:0] exp_of(input logic [63:0] addr, input logic err);
        logic [63:0] d;
        if (addr[1:0] != 2'b00) return {1'b1, 32'h00000013};
        d = mem_data({addr[63:3], 3'b000});
        return {err, addr[2] ? d[63:32] : d[31:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic start(input logic [63:0] addr, input logic err);
        ira      = addr;
        fetch_en = 1'b1;
        sb_q.push_back(exp_of(addr, err));
    endtask

    task automatic wait_ivalid(input string tag, input int budget);
        int n = 0;
        while (ivalid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(ivalid), 64'd1);
    endtask

    task automatic score(input string tag);
        logic [32:0] e;
        check_eq({tag, "_sb"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "_ir"}, 64'(ir), 64'(e[31:0]));
            check_eq({tag, "_ierr"}, 64'(ierr), 64'(e[32]));
        end
    endtask

    task automatic deliver(input string tag, input bit nxt_en, input logic [63:0] nxt, input logic nxt_err);
        score(tag);
        fetch_ready = 1'b1;
        fetch_en    = nxt_en;
        ira         = nxt;
        if (nxt_en) sb_q.push_back(exp_of(nxt, nxt_err));
        tick();
        fetch_ready = 1'b0;
    endtask

    // Memory responder: ready after ready_delay cycles, data resp_delay
    // cycles after the handshake; also watches request stability.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        mem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (pv && !pr && !flush && rst_n) begin
                check_eq("req_valid_hold", 64'(mem_req_valid), 64'd1);
                check_eq("req_addr_hold", mem_req_addr, pa);
            end
            pv = mem_req_valid;
            pa = mem_req_addr;
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = ovr_en ? ovr_data : mem_data(paddr);
                    mem_resp_err   = err_resp;
                    pend = 1'b0;
                    resp_count++;
                end else begin
                    pcnt--;
                end
            end
            mem_req_ready = 1'b0;
            if (!rst_n) begin
                rdy_wait = 0;
            end else if (mem_req_valid && !pend) begin
                if (rdy_wait >= ready_delay) begin
                    mem_req_ready = 1'b1;
                    pend     = 1'b1;
                    pcnt     = resp_delay;
                    paddr    = mem_req_addr;
                    rdy_wait = 0;
                    req_count++;
                end else begin
                    rdy_wait++;
                end
            end else if (!mem_req_valid) begin
                rdy_wait = 0;
            end
            pr = mem_req_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int bad;
        int n;
        rst_n = 1'b0; fetch_en = 1'b0; ira = 64'd0; fetch_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        check_eq("rst_ivalid", 64'(ivalid), 64'd0);
        check_eq("rst_ierr", 64'(ierr), 64'd0);
        check_eq("rst_ir", 64'(ir), 64'h13);
        check_eq("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_req_addr", mem_req_addr, 64'd0);
        rst_n = 1'b1;
        tick();

        // Miss latency
        start(64'h80000000, 1'b0);
        tick();
        check_eq("t1_req_valid_c1", 64'(mem_req_valid), 64'd1);
        check_eq("t1_req_addr_c1", mem_req_addr, 64'h80000000);
        tick();
        check_eq("t1_ivalid_c2", 64'(ivalid), 64'd0);
        tick();
        check_eq("t1_ivalid_c3", 64'(ivalid), 64'd1);
        rc0 = req_count;
        deliver("t1", 1'b1, 64'h80000004, 1'b0);

        // Upper word, back-pressure hold, line buffer behaviour
        check_eq("t2_b2b_ivalid", 64'(ivalid), 64'(LB));
        wait_ivalid("t2_wait", 20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2_hold_ivalid", 64'(ivalid), 64'd1);
            check_eq("t2_hold_ir", 64'(ir), 64'h00100093);
            check_eq("t2_hold_noreq", 64'(mem_req_valid), 64'd0);
        end
        check_eq("t2_req_count", 64'(req_count - rc0), LB ? 64'd0 : 64'd1);
        deliver("t2", 1'b0, 64'd0, 1'b0);
        tick();

        // Flush while waiting for the response
        resp_delay = 4; ovr_en = 1'b1; ovr_data = 64'hDEADBEEF_DEADBEEF;
        start(64'h80000100, 1'b0);
        tick();
        check_eq("t3_req_valid", 64'(mem_req_valid), 64'd1);
        tick();
        flush = 1'b1;
        ira   = 64'h80000208;
        void'(sb_q.pop_back());
        sb_q.push_back(exp_of(64'h80000208, 1'b0));
        rc0 = resp_count;
        tick();
        flush = 1'b0;
        bad = 0; n = 0;
        while (resp_count == rc0 && n < 20) begin
            if (ivalid) bad++;
            tick();
            n++;
        end
        check_eq("t3_resp_seen", 64'(resp_count != rc0), 64'd1);
        ovr_en = 1'b0; resp_delay = 0;
        n = 0;
        while (!mem_req_valid && n < 10) begin
            if (ivalid) bad++;
            tick();
            n++;
        end
        check_eq("t3_no_ivalid", 64'(bad), 64'd0);
        check_eq("t3_refetch_valid", 64'(mem_req_valid), 64'd1);
        check_eq("t3_refetch_addr", mem_req_addr, 64'h80000208);
        wait_ivalid("t3_wait", 20);
        deliver("t3", 1'b0, 64'd0, 1'b0);
        tick();

        // Misaligned address, then a bus error
        rc0 = req_count;
        start(64'h80000002, 1'b0);
        tick();
        check_eq("t4_mis_ivalid", 64'(ivalid), 64'd1);
        check_eq("t4_mis_noreq", 64'(mem_req_valid), 64'd0);
        err_resp = 1'b1;
        deliver("t4a", 1'b1, 64'h80000308, 1'b1);
        wait_ivalid("t4_wait", 20);
        err_resp = 1'b0;
        deliver("t4b", 1'b0, 64'd0, 1'b0);
        check_eq("t4_req_count", 64'(req_count - rc0), 64'd1);
        tick();

        // Slow ready: request must hold
        ready_delay = 3;
        start(64'h80000400, 1'b0);
        tick();
        check_eq("t5_req_valid", 64'(mem_req_valid), 64'd1);
        check_eq("t5_req_addr", mem_req_addr, 64'h80000400);
        wait_ivalid("t5_wait", 30);
        ready_delay = 0;
        deliver("t5", 1'b0, 64'd0, 1'b0);
        tick();

        // Flush in REQ before the handshake withdraws the request
        ready_delay = 5;
        start(64'h80000500, 1'b0);
        tick();
        check_eq("t6_req_valid", 64'(mem_req_valid), 64'd1);
        flush = 1'b1;
        ira   = 64'h80000600;
        void'(sb_q.pop_back());
        sb_q.push_back(exp_of(64'h80000600, 1'b0));
        ready_delay = 0;
        tick();
        flush = 1'b0;
        check_eq("t6_withdrawn", 64'(mem_req_valid), 64'd0);
        wait_ivalid("t6_wait", 20);
        deliver("t6", 1'b0, 64'd0, 1'b0);
        tick();

        // Flush and fetch_ready together: flush wins
        start(64'h80000800, 1'b0);
        wait_ivalid("t7_wait", 20);
        score("t7a");
        fetch_ready = 1'b1;
        flush       = 1'b1;
        ira         = 64'h80000900;
        sb_q.push_back(exp_of(64'h80000900, 1'b0));
        tick();
        fetch_ready = 1'b0;
        flush       = 1'b0;
        check_eq("t7_flush_wins", 64'(ivalid), 64'd0);
        wait_ivalid("t7_wait2", 20);
        deliver("t7b", 1'b0, 64'd0, 1'b0);
        tick();

        // Reset while waiting; late response must be ignored
        resp_delay = 3;
        start(64'h80000A00, 1'b0);
        tick();
        tick();
        rc0 = resp_count;
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        sb_q.delete();
        tick();
        check_eq("t8_rst_ivalid", 64'(ivalid), 64'd0);
        check_eq("t8_rst_req", 64'(mem_req_valid), 64'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ivalid || mem_req_valid) bad++;
        end
        check_eq("t8_late_resp_seen", 64'(resp_count != rc0), 64'd1);
        check_eq("t8_ignored", 64'(bad), 64'd0);
        check_eq("t8_ir_reset", 64'(ir), 64'h13);
        resp_delay = 0;

        // Normal fetch after reset
        start(64'h80000B04, 1'b0);
        wait_ivalid("t9_wait", 20);
        deliver("t9", 1'b0, 64'd0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
